// File: rtl/button_pkg.sv
`default_nettype none
// ============================================================================
// Module      : button_pkg
// Description : Shared constants and types for the button/equalizer reader.
//               Holds the bus widths, the peripheral register map and the
//               state encoding of the read-sequencing FSM.
// Revision    : 1.0 - initial release
// ============================================================================
package button_pkg;

    // Bus widths of the button/equalizer peripheral interface
    localparam int c_data_w = 24;
    localparam int c_addr_w = 2;

    // Peripheral register map
    localparam logic [c_addr_w-1:0] c_rd_addr_status = 2'b00;
    localparam logic [c_addr_w-1:0] c_rd_addr_eq     = 2'b01;
    localparam logic [c_addr_w-1:0] c_rd_addr_cfg    = 2'b10;
    localparam logic [c_addr_w-1:0] c_rd_addr_id     = 2'b11;

    // Read-sequencer state encoding
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_LOW = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/button_evt_fifo.sv
`default_nettype none
// ============================================================================
// Module      : button_evt_fifo
// Description : Synchronous first-word-fall-through FIFO for event words.
//               When push and pop coincide the pop is taken first, so a
//               push into a full FIFO that is also being popped is accepted.
//               o_data shows the head word while not empty and keeps the
//               last head word once the FIFO drains.
// Ports       : clk, rst (async, active-low)
//               i_push/i_data   - write request and word
//               i_pop           - read request (ignored when empty)
//               o_data          - head word
//               o_full/o_empty  - status
//               o_count         - occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module button_evt_fifo #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [DATA_W-1:0]          i_data,
    input  logic                       i_pop,
    output logic [DATA_W-1:0]          o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH + 1);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic [DATA_W-1:0]  r_hold;

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_cnt_w'(DEPTH));
    assign w_do_pop  = i_pop & ~w_empty;
    // A simultaneous pop frees the slot this push needs
    assign w_do_push = i_push & (~w_full | w_do_pop);

    // Storage needs no reset: it is only observed while non-empty
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_hold   <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
            // Track the head so the output can hold it after the last pop
            if (!w_empty) begin
                r_hold <= r_mem[r_rd_ptr];
            end
        end
    end

    assign o_data  = w_empty ? r_hold : r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/button_reader.sv
`default_nettype none
// ============================================================================
// Module      : button_reader
// Description : Bus master that reads the button/equalizer peripheral once
//               per interrupt assertion, queues the returned word in an
//               event FIFO and flags bus timeouts and FIFO overflow.
// Ports       : clk, rst (async, active-low)
//               fpga_int            - level interrupt from the peripheral
//               fpga_drdy/fpga_data - read response
//               fpga_ce/fpga_addr   - read strobe and address (registered)
//               evt_valid/evt_data  - FIFO head, evt_ready pops it
//               evt_count           - FIFO occupancy
//               overflow            - sticky: word dropped on a full FIFO
//               timeout_err         - sticky: read got no fpga_drdy
//               err_clr             - clears both sticky flags
// Revision    : 1.0 - initial release
// ============================================================================
module button_reader #(
    parameter int                      DATA_W     = button_pkg::c_data_w,
    parameter int                      ADDR_W     = button_pkg::c_addr_w,
    parameter logic [ADDR_W-1:0]       RD_ADDR    = button_pkg::c_rd_addr_status,
    parameter int                      FIFO_DEPTH = 8,
    parameter int                      TIMEOUT    = 255
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            fpga_int,
    input  logic                            fpga_drdy,
    input  logic [DATA_W-1:0]               fpga_data,
    output logic                            fpga_ce,
    output logic [ADDR_W-1:0]               fpga_addr,
    output logic                            evt_valid,
    output logic [DATA_W-1:0]               evt_data,
    input  logic                            evt_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] evt_count,
    output logic                            overflow,
    output logic                            timeout_err,
    input  logic                            err_clr
);

    import button_pkg::*;

    localparam int                c_tmo_w    = $clog2(TIMEOUT + 1);
    // Last count value before the counter reaches TIMEOUT
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT - 1);

    state_t              r_state;
    logic                r_ce;
    logic [ADDR_W-1:0]   r_addr;
    logic [c_tmo_w-1:0]  r_tmo_cnt;
    logic                r_overflow;
    logic                r_timeout_err;

    logic w_push;
    logic w_pop;
    logic w_full;
    logic w_empty;
    logic w_tmo_hit;
    logic w_ovf_set;

    // Data wins over a timeout landing in the same cycle
    assign w_push    = (r_state == ST_REQ) & fpga_drdy;
    assign w_tmo_hit = (r_state == ST_REQ) & ~fpga_drdy & (r_tmo_cnt == c_tmo_last);
    assign w_pop     = ~w_empty & evt_ready;
    // Full with no pop means the captured word has nowhere to go
    assign w_ovf_set = w_push & w_full & ~w_pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_ce          <= 1'b0;
            r_addr        <= '0;
            r_tmo_cnt     <= '0;
            r_overflow    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_tmo_cnt <= '0;
                    if (fpga_int) begin
                        r_state <= ST_REQ;
                        r_ce    <= 1'b1;
                        r_addr  <= RD_ADDR;
                    end
                end
                ST_REQ: begin
                    if (!fpga_drdy) begin
                        r_tmo_cnt <= r_tmo_cnt + c_tmo_w'(1);
                    end
                    if (fpga_drdy || w_tmo_hit) begin
                        r_state <= ST_WAIT_LOW;
                        r_ce    <= 1'b0;
                        r_addr  <= '0;
                    end
                end
                ST_WAIT_LOW: begin
                    // Re-arm only after the interrupt drops: one read per assertion
                    r_addr <= '0;
                    if (!fpga_int) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ce    <= 1'b0;
                    r_addr  <= '0;
                end
            endcase

            // Sticky flags: a new event takes priority over a clear
            r_overflow    <= w_ovf_set | (r_overflow & ~err_clr);
            r_timeout_err <= w_tmo_hit | (r_timeout_err & ~err_clr);
        end
    end

    button_evt_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_evt_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (fpga_data),
        .i_pop   (w_pop),
        .o_data  (evt_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (evt_count)
    );

    assign fpga_ce     = r_ce;
    assign fpga_addr   = r_addr;
    assign evt_valid   = ~w_empty;
    assign overflow    = r_overflow;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_button_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_reader
// Description : Directed self-checking bench for button_reader with a small
//               behavioural peripheral (drdy after a chosen latency).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_reader;

    localparam int c_data_w = 24;
    localparam int c_depth  = 8;
    localparam int c_tmo    = 16;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                fpga_int = 1'b0;
    logic                fpga_drdy = 1'b0;
    logic [c_data_w-1:0] fpga_data = '0;
    logic                fpga_ce;
    logic [1:0]          fpga_addr;
    logic                evt_valid;
    logic [c_data_w-1:0] evt_data;
    logic                evt_ready = 1'b0;
    logic [3:0]          evt_count;
    logic                overflow;
    logic                timeout_err;
    logic                err_clr = 1'b0;

    int n_vec  = 0;
    int n_miss = 0;
    int addr_bad = 0;

    always #5 clk = ~clk;

    button_reader #(
        .DATA_W     (c_data_w),
        .ADDR_W     (2),
        .RD_ADDR    (2'b00),
        .FIFO_DEPTH (c_depth),
        .TIMEOUT    (c_tmo)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fpga_int    (fpga_int),
        .fpga_drdy   (fpga_drdy),
        .fpga_data   (fpga_data),
        .fpga_ce     (fpga_ce),
        .fpga_addr   (fpga_addr),
        .evt_valid   (evt_valid),
        .evt_data    (evt_data),
        .evt_ready   (evt_ready),
        .evt_count   (evt_count),
        .overflow    (overflow),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Raise the interrupt and act as the peripheral: drdy in the lat-th
    // cycle of fpga_ce (lat=0 never answers). Returns cycles ce was high.
    // With pop_at_push the CPU pops in the same cycle as the capture.
    task automatic do_read(input logic [c_data_w-1:0] d, input int lat,
                           input bit pop_at_push, output int ce_cycles);
        int guard;
        ce_cycles = 0;
        guard     = 0;
        fpga_int  = 1'b1;
        @(negedge clk);
        while (!fpga_ce && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        while (fpga_ce && guard < 400) begin
            ce_cycles++;
            if (fpga_addr !== 2'b00) addr_bad++;
            if (ce_cycles == lat) begin
                fpga_drdy = 1'b1;
                fpga_data = d;
                if (pop_at_push) evt_ready = 1'b1;
            end
            @(negedge clk);
            fpga_drdy = 1'b0;
            evt_ready = 1'b0;
            guard++;
        end
    endtask

    task automatic release_int();
        fpga_int = 1'b0;
        @(negedge clk);
    endtask

    task automatic pop_one(output logic [c_data_w-1:0] d);
        d = evt_data;
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    initial begin
        int                  ce_n;
        int                  retrig;
        int                  max_cnt;
        logic [c_data_w-1:0] got;
        logic [c_data_w-1:0] exp_next;

        // ---------------- reset state ----------------
        #12;
        check_val("rst_ce", fpga_ce, 0);
        check_val("rst_addr", fpga_addr, 0);
        check_val("rst_valid", evt_valid, 0);
        check_val("rst_count", evt_count, 0);
        check_val("rst_data", evt_data, 0);
        check_val("rst_flags", {overflow, timeout_err}, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // ---------------- basic read ----------------
        do_read(24'h000001, 3, 1'b0, ce_n);
        check_val("basic_ce_cycles", ce_n, 3);
        check_val("basic_addr", addr_bad, 0);
        check_val("basic_valid", evt_valid, 1);
        check_val("basic_data", evt_data, 24'h000001);
        check_val("basic_count", evt_count, 1);
        retrig = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (fpga_ce) retrig++;
        end
        check_val("basic_no_retrigger", retrig, 0);
        release_int();
        pop_one(got);
        check_val("basic_pop", got, 24'h000001);
        check_val("basic_empty", {evt_valid, evt_count}, 0);
        check_val("basic_hold_last", evt_data, 24'h000001);

        // ---------------- ordering / wrap ----------------
        exp_next = 24'd1;
        max_cnt  = 0;
        for (int i = 1; i <= 10; i++) begin
            do_read(24'(i), 2, 1'b0, ce_n);
            release_int();
            if (evt_count > max_cnt) max_cnt = evt_count;
            if (i % 3 == 0) begin
                for (int k = 0; k < 2; k++) begin
                    pop_one(got);
                    check_val("order_pop", got, exp_next);
                    exp_next++;
                end
            end
        end
        while (evt_valid && exp_next < 24'd20) begin
            pop_one(got);
            check_val("order_drain", got, exp_next);
            exp_next++;
        end
        check_val("order_all_popped", exp_next, 24'd11);
        check_val("order_max_le8", (max_cnt <= 8), 1);
        check_val("order_no_ovf", overflow, 0);

        // ---------------- overflow ----------------
        for (int i = 0; i < 9; i++) begin
            do_read(24'h000100 + 24'(i), 2, 1'b0, ce_n);
            release_int();
        end
        check_val("ovf_count", evt_count, 8);
        check_val("ovf_flag", overflow, 1);
        check_val("ovf_head", evt_data, 24'h000100);
        pulse_clr();
        check_val("ovf_cleared", overflow, 0);
        do_read(24'h0001FF, 2, 1'b1, ce_n);
        release_int();
        check_val("ovf_pp_count", evt_count, 8);
        check_val("ovf_pp_no_flag", overflow, 0);
        check_val("ovf_pp_head", evt_data, 24'h000101);
        for (int i = 1; i < 8; i++) begin
            pop_one(got);
            check_val("ovf_pp_seq", got, 24'h000100 + 24'(i));
        end
        pop_one(got);
        check_val("ovf_pp_new_word", got, 24'h0001FF);
        check_val("ovf_pp_empty", evt_count, 0);

        // ---------------- timeout ----------------
        do_read(24'hDEAD00, 0, 1'b0, ce_n);
        check_val("tmo_ce_cycles", ce_n, c_tmo);
        check_val("tmo_flag", timeout_err, 1);
        check_val("tmo_count", evt_count, 0);
        release_int();
        do_read(24'h000ABC, 4, 1'b0, ce_n);
        release_int();
        check_val("tmo_next_ce", ce_n, 4);
        check_val("tmo_next_data", evt_data, 24'h000ABC);
        check_val("tmo_flag_sticky", timeout_err, 1);
        pulse_clr();
        check_val("tmo_cleared", timeout_err, 0);
        pop_one(got);

        // ---------------- boundary: drdy in the last cycle ----------------
        do_read(24'h5A5A5A, c_tmo, 1'b0, ce_n);
        release_int();
        check_val("bnd_ce_cycles", ce_n, c_tmo);
        check_val("bnd_no_tmo", timeout_err, 0);
        check_val("bnd_count", evt_count, 1);
        check_val("bnd_data", evt_data, 24'h5A5A5A);

        // ---------------- async reset mid-REQ ----------------
        do_read(24'h0, 0, 1'b0, ce_n);
        release_int();
        fpga_int = 1'b1;
        @(negedge clk);
        check_val("arst_in_req", fpga_ce, 1);
        #2 rst = 1'b0;
        #1;
        check_val("arst_ce", fpga_ce, 0);
        check_val("arst_count", evt_count, 0);
        check_val("arst_flags", {overflow, timeout_err, evt_valid}, 0);
        fpga_int = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        do_read(24'h000077, 3, 1'b0, ce_n);
        release_int();
        check_val("arst_after_ce", ce_n, 3);
        check_val("arst_after_data", evt_data, 24'h000077);
        check_val("arst_after_count", evt_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/button_reader.md
Name: button_reader

Overview:
- FPGA-core-side bus master for the button/equalizer peripheral.
- Reacts to the peripheral's interrupt by issuing a read transaction: asserts fpga_ce with fpga_addr and waits for fpga_drdy.
- Captures the 24-bit button/event word and queues it in a small first-word-fall-through event FIFO for the CPU.
- Flags bus timeouts and FIFO overflow as sticky errors.

Parameters:
- DATA_W, 24, width of fpga_data and of event words
- ADDR_W, 2, width of fpga_addr
- RD_ADDR, 2'b00, register address read on each interrupt
- FIFO_DEPTH, 8, event FIFO entries; power of two, minimum 2
- TIMEOUT, 255, maximum cycles fpga_ce is held waiting for fpga_drdy; minimum 1

Ports:
- clk, input, 1, system clock
- rst, input, 1, asynchronous active-low reset
- fpga_int, input, 1, level interrupt from the button peripheral; synchronous to clk
- fpga_drdy, input, 1, read data valid from the peripheral
- fpga_data, input, DATA_W, read data from the peripheral
- fpga_ce, output, 1, read strobe to the peripheral
- fpga_addr, output, ADDR_W, read address to the peripheral
- evt_valid, output, 1, FIFO not empty
- evt_data, output, DATA_W, FIFO head word
- evt_ready, input, 1, CPU pop; honoured only when evt_valid=1
- evt_count, output, clog2(FIFO_DEPTH+1), current occupancy
- overflow, output, 1, sticky: a captured word was dropped because the FIFO was full
- timeout_err, output, 1, sticky: a read got no fpga_drdy within TIMEOUT cycles
- err_clr, input, 1, synchronous clear of both sticky flags

Behaviour:
- Reset (rst=0, asynchronous): FSM to IDLE; fpga_ce=0; fpga_addr=0; FIFO emptied; evt_valid=0, evt_count=0; evt_data=0; overflow=0, timeout_err=0; timeout counter=0.
- Reset mid-transaction: fpga_ce drops immediately; the in-flight read is abandoned; no FIFO write.
- FSM states: IDLE, REQ, WAIT_LOW.
- IDLE:
  - fpga_int=1 sampled -> REQ next cycle.
  - fpga_ce=1 and fpga_addr=RD_ADDR are registered, so they appear in the first REQ cycle (1-cycle latency from int).
  - Timeout counter loads 0.
- REQ:
  - fpga_ce and fpga_addr are held.
  - Counter increments each cycle that fpga_drdy=0.
  - fpga_drdy=1 sampled: fpga_data is captured that edge; FIFO push is attempted; fpga_ce=0 next cycle; -> WAIT_LOW.
  - Counter reaches TIMEOUT with fpga_drdy=0: fpga_ce=0 next cycle; timeout_err<=1; no push; -> WAIT_LOW.
  - If fpga_drdy=1 in the same cycle the counter hits TIMEOUT, the data wins: normal capture, no timeout_err.
- WAIT_LOW:
  - fpga_addr returns to 0.
  - Stays until fpga_int=0 is sampled, then -> IDLE.
  - This guarantees one read per interrupt assertion. An int held high after the read never retriggers.
  - Minimum gap between reads is 2 cycles.
- FIFO:
  - Registered pointers, log2(FIFO_DEPTH) bits each, natural wrap-around; separate occupancy counter.
  - evt_data shows the head word combinationally from storage whenever evt_valid=1; it holds its last value when empty.
  - Pop: evt_valid & evt_ready. Pop on empty is ignored.
  - Push when count<FIFO_DEPTH: write data; count+1.
  - Push when full with no pop: word dropped; overflow<=1; count unchanged.
  - Push and pop in the same cycle: pop is processed first, so the push is always accepted; count unchanged, including when full.
  - evt_count and evt_valid update on the clock edge after the push or pop.
- Sticky flags:
  - err_clr=1 clears both flags.
  - If err_clr coincides with a new error event, the set wins and the flag stays 1.

Decomposition:
- Shared package (button_pkg): DATA_W, ADDR_W, register address constants (RD_ADDR_STATUS=2'b00, etc.), FSM state encoding enum.
- One sub-module: button_evt_fifo (parameterised synchronous FWFT FIFO with push, pop, full, empty, count).
- FSM, timeout counter and sticky flags live in the top.

Test Plan:
- Basic read: fpga_int=1 held; peripheral model returns drdy 3 cycles after ce with data 24'h000001 -> ce high exactly 3 cycles, addr=0; evt_valid=1 with evt_data=24'h000001, evt_count=1; int held high 50 more cycles -> no second ce.
- Ordering/wrap: 10 interrupt/read cycles with data 1..10, popping 2 after every 3 reads -> popped sequence strictly 1..10; count never exceeds 8; overflow=0.
- Overflow: 9 reads, no pops -> count=8, overflow=1, head=first word; simultaneous push+pop while full -> count stays 8, the new word is stored, overflow not newly set after err_clr.
- Timeout: TIMEOUT=16, drdy never asserted -> ce high exactly 16 cycles then low; timeout_err=1; count unchanged; int drop then re-raise -> new read works; err_clr -> timeout_err=0.
- Boundary: drdy asserted in the 16th cycle (TIMEOUT=16) -> word captured, timeout_err=0.
- Async reset: assert rst=0 mid-REQ, between clock edges -> ce=0 immediately, count=0, flags=0; after release, a new int gives a normal read.
